// File: rtl/opr_sequencer.sv
// Calculator front end: debounced button steps the A/B/op loads, then captures the compute-stage result.
// Optional trace of FSM transitions and captures when OPR_SEQ_TRACE_EN is defined.

package types_pkg;
  parameter int BITS = 16;

  typedef logic [BITS-1:0]   word_t;
  typedef logic [BITS/2-1:0] word_half_t;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    ADD    = 3'd1,
    SUB    = 3'd2,
    MUL    = 3'd3,
    AND_OP = 3'd4,
    OR_OP  = 3'd5,
    XOR_OP = 3'd6
  } opr_mode_t;

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_OP   = 3'd2,
    ST_EXEC = 3'd3,
    ST_SHOW = 3'd4
  } seq_state_t;
endpackage

module opr_sequencer
  import types_pkg::*;
#(
  parameter int BITS            = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESULT_LATENCY  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  word_half_t sw_in,
  input  opr_mode_t  op_in,
  output opr_mode_t  SELECTOR,
  output word_t      SW,
  input  word_t      result_in,
  output word_t      result_out,
  output logic       result_valid,
  output logic       busy
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LAT_W = $clog2(RESULT_LATENCY + 1);

  if ((BITS % 2) != 0 || BITS != types_pkg::BITS || DEBOUNCE_CYCLES < 1 || RESULT_LATENCY < 1)
  begin : g_bad_params
    $error("opr_sequencer: illegal parameter combination");
  end

  // Handshake: there is no valid/ready pair here; a one-cycle press pulse is the only
  // advance strobe, and result_valid stays high until the next A load consumes the display.

  logic            sync1, sync2, stable, stable_d, press;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn_next;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      // Any sample agreeing with the stable level restarts the run count.
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  seq_state_t       state, state_n;
  opr_mode_t        op_q, op_map;
  logic [LAT_W-1:0] cnt;
  logic             load_a, load_b, load_op, capture;

  always_comb begin
    case (op_in)
      ADD, SUB, MUL, AND_OP, OR_OP, XOR_OP: op_map = op_in;
      default:                              op_map = RESET;
    endcase
  end

  always_comb begin
    state_n  = state;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_op  = 1'b0;
    capture  = 1'b0;
    busy     = 1'b0;
    SELECTOR = RESET;
    case (state)
      ST_A: if (press) begin
        load_a  = 1'b1;
        state_n = ST_B;
      end
      ST_B: if (press) begin
        load_b  = 1'b1;
        state_n = ST_OP;
      end
      ST_OP: if (press) begin
        load_op = 1'b1;
        state_n = ST_EXEC;
      end
      ST_EXEC: begin
        busy     = 1'b1;
        SELECTOR = op_q;
        if (cnt == LAT_W'(1)) begin
          capture = 1'b1;
          state_n = ST_SHOW;
        end
      end
      ST_SHOW: begin
        // Keep the operation applied so the displayed result's source stays stable.
        SELECTOR = op_q;
        if (press) state_n = ST_A;
      end
      default: state_n = ST_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_A;
      op_q         <= RESET;
      cnt          <= '0;
      SW           <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (load_a) begin
        SW[BITS/2-1:0] <= sw_in;
        result_valid   <= 1'b0;
      end
      if (load_b) SW[BITS-1:BITS/2] <= sw_in;
      if (load_op) begin
        op_q <= op_map;
        cnt  <= LAT_W'(RESULT_LATENCY);
      end else if (state == ST_EXEC) begin
        cnt <= cnt - LAT_W'(1);
      end
      if (capture) begin
        result_out   <= result_in;
        result_valid <= 1'b1;
      end
    end
  end

`ifdef OPR_SEQ_TRACE_EN
  always @(posedge clk) begin
    if (!rst && state_n != state) begin
      $display("%0t opr_sequencer: %s -> %s SW=%h op_q=%s",
               $time, state.name(), state_n.name(), SW, op_q.name());
      if (capture) $display("%0t opr_sequencer: result_out=%h (%0d)", $time, result_in, result_in);
    end
  end
`else
  // Trace disabled: the block is silent in simulation.
`endif

endmodule
